wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arb_fifo.sv | 60 ++++++
 rtl/wb_arbiter.sv | 84 ++++++++
 tb/tb_wb_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, write-request type and rd one-hot helper for the writeback arbiter
package wb_arb_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
  function automatic logic [NUM_REGS-1:0] rdOneHot(input logic [REG_ADDR_W-1:0] rd);
    rdOneHot = '0;
    rdOneHot[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: DEPTH-entry aux result queue with per-entry valid and rd-match kill
// Ports: clk, reset (async, high); push/pushRd/pushData enqueue; pop dequeues head;
//        killEn/killRd invalidate queued entries with that rd; headRd/headData/headValid
//        describe the head; count is occupancy (killed entries still occupy a slot
//        until popped); pendMask is the OR of one-hot rd of valid entries.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [REG_ADDR_W-1:0]          pushRd,
  input  logic [XLEN-1:0]                pushData,
  input  logic                           pop,
  input  logic                           killEn,
  input  logic [REG_ADDR_W-1:0]          killRd,
  output logic [REG_ADDR_W-1:0]          headRd,
  output logic [XLEN-1:0]                headData,
  output logic                           headValid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [NUM_REGS-1:0]            pendMask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  wb_req_t mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] wrPtr, rdPtr;
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= '{rd: pushRd, data: pushData};
  // Kills apply first; pop then push override per slot (push slot is always free).
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (killEn && mem[i].rd == killRd) valid[i] <= 1'b0;
      if (pop) begin
        valid[rdPtr] <= 1'b0;
        rdPtr <= rdPtr + 1'b1;
      end
      if (push) begin
        valid[wrPtr] <= 1'b1;
        wrPtr <= wrPtr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  assign headRd = mem[rdPtr].rd;
  assign headData = mem[rdPtr].data;
  assign headValid = valid[rdPtr];
  always_comb begin
    pendMask = '0;
    for (int i = 0; i < DEPTH; i++)
      pendMask = pendMask | (valid[i] ? rdOneHot(mem[i].rd) : '0);
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: single regfile write-port arbiter between writeback pipe and aux (mul/div) results
// Ports: clk, reset (async, high); pipe_wen/pipe_rd/pipe_data writeback request;
//        aux_valid/aux_rd/aux_data/aux_ready aux handshake; rf_wen/rf_rd/rf_data registered
//        regfile write; pipe_stall holds writeback when the starve guard forces the queue;
//        pend_rd_mask flags rds with queued aux results.
// Build option: WB_ARBITER_STARVE_GUARD_EN enables the starvation counter and pipe_stall.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        aux_valid,
  input  logic [4:0]  aux_rd,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        pipe_stall,
  output logic [31:0] pend_rd_mask
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count;
  logic [REG_ADDR_W-1:0] headRd;
  logic [XLEN-1:0] headData;
  logic headValid, pipeHit, headAvail, forceHead, grantPipe, grantHead, headWrite, push;
  assign pipeHit = pipe_wen && pipe_rd != '0;
  assign headAvail = count != '0;
  assign grantPipe = pipeHit && !forceHead;
  assign grantHead = headAvail && (forceHead || !pipeHit);
  // A killed head is still popped on its grant, just without a write.
  assign headWrite = grantHead && headValid;
  assign aux_ready = !reset && count < CW'(DEPTH);
  // An aux result landing on the same edge as a younger pipe write to its rd is stale.
  assign push = aux_valid && aux_ready && aux_rd != '0 && !(grantPipe && pipe_rd == aux_rd);
  assign pipe_stall = forceHead;
  wb_arb_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pushRd(aux_rd),
    .pushData(aux_data),
    .pop(grantHead),
    .killEn(grantPipe),
    .killRd(pipe_rd),
    .headRd(headRd),
    .headData(headData),
    .headValid(headValid),
    .count(count),
    .pendMask(pend_rd_mask)
  );
`ifdef WB_ARBITER_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starveCnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) starveCnt <= '0;
    else if (grantHead || !headAvail) starveCnt <= '0;
    else if (grantPipe) starveCnt <= starveCnt + 1'b1;
  assign forceHead = headAvail && starveCnt == SW'(STARVE_LIMIT);
`else
  assign forceHead = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rf_wen <= 1'b0;
      rf_rd <= '0;
      rf_data <= '0;
    end else begin
      rf_wen <= grantPipe || headWrite;
      if (grantPipe) begin
        rf_rd <= pipe_rd;
        rf_data <= pipe_data;
      end else if (headWrite) begin
        rf_rd <= headRd;
        rf_data <= headData;
      end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (DEPTH=2, STARVE_LIMIT=4)
module tb_wb_arbiter;
  logic clk = 0, reset = 0, pipe_wen = 0, aux_valid = 0;
  logic [4:0] pipe_rd = 0, aux_rd = 0, rf_rd;
  logic [31:0] pipe_data = 0, aux_data = 0, rf_data, pend_rd_mask;
  logic aux_ready, rf_wen, pipe_stall;
  int checks = 0, errors = 0;
  logic [4:0] wrRd[$];
  logic [31:0] wrData[$];
  always #5 clk = ~clk;
  wb_arbiter dut (
    .clk(clk),
    .reset(reset),
    .pipe_wen(pipe_wen),
    .pipe_rd(pipe_rd),
    .pipe_data(pipe_data),
    .aux_valid(aux_valid),
    .aux_rd(aux_rd),
    .aux_data(aux_data),
    .aux_ready(aux_ready),
    .rf_wen(rf_wen),
    .rf_rd(rf_rd),
    .rf_data(rf_data),
    .pipe_stall(pipe_stall),
    .pend_rd_mask(pend_rd_mask)
  );
  always @(negedge clk)
    if (rf_wen) begin
      wrRd.push_back(rf_rd);
      wrData.push_back(rf_data);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clearLog;
    wrRd.delete();
    wrData.delete();
  endtask
  initial begin
    int n;
    #1 reset = 1;
    #1;
    check("rst_wen", rf_wen, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_data", rf_data, 0);
    check("rst_mask", pend_rd_mask, 0);
    check("rst_stall", pipe_stall, 0);
    check("rst_ready", aux_ready, 0);
    tick;
    tick;
    reset = 0;
    #1 check("ready_after_rst", aux_ready, 1);
    aux_valid = 1; aux_rd = 5; aux_data = 32'h1234;
    tick;
    aux_valid = 0;
    check("t1_no_early_wen", rf_wen, 0);
    check("t1_mask", pend_rd_mask, 32'h20);
    tick;
    check("t1_wen", rf_wen, 1);
    check("t1_rd", rf_rd, 5);
    check("t1_data", rf_data, 32'h1234);
    check("t1_mask_clear", pend_rd_mask, 0);
    tick;
    check("t1_idle_wen", rf_wen, 0);
    check("t1_hold_rd", rf_rd, 5);
    pipe_wen = 1; pipe_rd = 3; pipe_data = 32'hA;
    aux_valid = 1; aux_rd = 7; aux_data = 32'h77;
    tick;
    aux_valid = 0;
    check("t2_rd", rf_rd, 3);
    check("t2_data", rf_data, 32'hA);
    check("t2_mask", pend_rd_mask, 32'h80);
`ifdef WB_ARBITER_STARVE_GUARD_EN
    for (int i = 2; i <= 5; i++) begin
      tick;
      check("t2_pipe_rd", rf_rd, 3);
      check("t2_stall", pipe_stall, i == 5);
    end
    tick;
    check("t2_forced_rd", rf_rd, 7);
    check("t2_forced_data", rf_data, 32'h77);
    check("t2_stall_clear", pipe_stall, 0);
    pipe_wen = 0;
    tick;
    check("t2_idle", rf_wen, 0);
`else
    for (int i = 0; i < 6; i++) begin
      tick;
      check("t2_pipe_rd", rf_rd, 3);
      check("t2_stall", pipe_stall, 0);
      check("t2_mask_wait", pend_rd_mask, 32'h80);
    end
    pipe_wen = 0;
    tick;
    check("t2_aux_rd", rf_rd, 7);
    check("t2_aux_data", rf_data, 32'h77);
    tick;
    check("t2_idle", rf_wen, 0);
`endif
    pipe_wen = 1; pipe_rd = 10; pipe_data = 32'hB;
    aux_valid = 1; aux_rd = 1; aux_data = 32'h101;
    check("t3_ready0", aux_ready, 1);
    tick;
    aux_rd = 2; aux_data = 32'h102;
    check("t3_ready1", aux_ready, 1);
    tick;
    aux_rd = 3; aux_data = 32'h103;
    check("t3_full", aux_ready, 0);
    check("t3_mask", pend_rd_mask, 32'h6);
    repeat (2) begin
      tick;
      check("t3_held", aux_ready, 0);
      check("t3_pipe_rd", rf_rd, 10);
    end
    pipe_wen = 0;
    tick;
    check("t3_first_rd", rf_rd, 1);
    check("t3_first_data", rf_data, 32'h101);
    check("t3_ready_again", aux_ready, 1);
    tick;
    aux_valid = 0;
    check("t3_second_rd", rf_rd, 2);
    check("t3_second_data", rf_data, 32'h102);
    tick;
    check("t3_third_wen", rf_wen, 1);
    check("t3_third_rd", rf_rd, 3);
    check("t3_third_data", rf_data, 32'h103);
    tick;
    check("t3_idle", rf_wen, 0);
    clearLog();
    pipe_wen = 1; pipe_rd = 10; pipe_data = 32'hC;
    aux_valid = 1; aux_rd = 9; aux_data = 32'h99;
    tick;
    aux_valid = 0;
    check("t4_mask", pend_rd_mask, 32'h200);
    pipe_rd = 9; pipe_data = 32'h55;
    tick;
    check("t4_rd", rf_rd, 9);
    check("t4_data", rf_data, 32'h55);
    check("t4_mask_clear", pend_rd_mask, 0);
    pipe_wen = 0;
    tick;
    check("t4_drop_wen", rf_wen, 0);
    tick;
    check("t4_idle", rf_wen, 0);
    n = 0;
    foreach (wrRd[i]) if (wrRd[i] == 9) begin
      n++;
      check("t4_x9_data", wrData[i], 32'h55);
    end
    check("t4_x9_writes", n, 1);
    clearLog();
    pipe_wen = 1; pipe_rd = 10; pipe_data = 32'hD;
    aux_valid = 1; aux_rd = 4; aux_data = 32'h44;
    tick;
    aux_valid = 0;
    pipe_rd = 0; pipe_data = 32'hFF;
    tick;
    check("t5_head_wen", rf_wen, 1);
    check("t5_head_rd", rf_rd, 4);
    check("t5_head_data", rf_data, 32'h44);
    pipe_wen = 0;
    aux_valid = 1; aux_rd = 0; aux_data = 32'hE0;
    check("t5_ready", aux_ready, 1);
    tick;
    aux_valid = 0;
    check("t5_rd0_wen", rf_wen, 0);
    check("t5_rd0_mask", pend_rd_mask, 0);
    tick;
    check("t5_rd0_later", rf_wen, 0);
    check("t5_log_size", wrRd.size(), 2);
    n = 0;
    foreach (wrRd[i]) if (wrRd[i] == 0) n++;
    check("t5_no_x0", n, 0);
    pipe_wen = 1; pipe_rd = 10; pipe_data = 32'hF;
    aux_valid = 1; aux_rd = 12; aux_data = 32'h12;
    tick;
    aux_rd = 13; aux_data = 32'h13;
    tick;
    aux_valid = 0;
    check("t6_mask", pend_rd_mask, 32'h3000);
    pipe_wen = 0;
    reset = 1;
    #1;
    check("t6_wen", rf_wen, 0);
    check("t6_rd", rf_rd, 0);
    check("t6_mask_rst", pend_rd_mask, 0);
    check("t6_ready_rst", aux_ready, 0);
    check("t6_stall_rst", pipe_stall, 0);
    clearLog();
    tick;
    tick;
    reset = 0;
    #1 check("t6_ready_after", aux_ready, 1);
    repeat (3) tick;
    check("t6_no_writes", wrRd.size(), 0);
    check("t6_idle", rf_wen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
